multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. Sequences instruction fetch, decode, execute, memory and write-back over several cycles, driving the datapath mux selects and write enables. Emits the 3-bit ALUOp consumed by the existing ALU decoder, which turns ALUOp plus funct into ALUControl. Stalls on a memory ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 98 +++++++++
 rtl/ctrl_output_decode.sv | 111 +++++++++++
 rtl/multicycle_control.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main control FSM:
//   - opcode constants (instruction[31:26])
//   - FSM state encoding (4-bit, FETCH = 0 upward)
//   - ALUOp codes consumed by the downstream ALU decoder
//   - ALUSrcB and PCSrc select constants
//   - packed control-vector layout shared by the decoder and the top level
//   - decode_target(): DECODE-state dispatch by opcode
// Optional feature macro: BNE_EN (adds bne support to the dispatch).
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // FSM states
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_ADDIEX  = 4'd8,
    S_ORIEX   = 4'd9,
    S_IWB     = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  // ALUOp codes
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_BEQ   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_ORI   = 3'b011;
  localparam logic [2:0] ALUOP_SUB   = 3'b100;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSrc selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control vector, MSB first
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       illegal_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Dispatch target out of DECODE. S_FETCH doubles as the "unsupported
  // opcode" marker because no legal opcode returns straight to FETCH.
  function automatic state_t decode_target(input logic [5:0] op);
    state_t tgt;
    case (op)
      OP_LW, OP_SW: tgt = S_MEMADR;
      OP_RTYPE:     tgt = S_EXECUTE;
      OP_BEQ:       tgt = S_BRANCH;
      OP_ADDI:      tgt = S_ADDIEX;
      OP_ORI:       tgt = S_ORIEX;
      OP_J:         tgt = S_JUMP;
`ifdef BNE_EN
      OP_BNE:       tgt = S_BRANCH;
`endif
      default:      tgt = S_FETCH;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// ---------------------------------------------------------------------------
// ctrl_output_decode
// Combinational mapping from FSM state (plus opcode and mem_ready) to the
// datapath control vector. Any field not set by a state stays 0.
// Ports:
//   state_i     in  4            current FSM state (mips_ctrl_pkg::state_t)
//   opcode_i    in  6            instruction opcode from the IR
//   mem_ready_i in  1            memory handshake (only matters in FETCH)
//   ctrl_o      out CTRL_W       packed mips_ctrl_pkg::ctrl_t
// Optional feature macro: BNE_EN (bne variant of the BRANCH state).
// ---------------------------------------------------------------------------
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]        state_i,
  input  logic [5:0]        opcode_i,
  input  logic              mem_ready_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  state_t state_s;
  ctrl_t  ctrl_s;

  assign state_s = state_t'(state_i);
  assign ctrl_o  = ctrl_s;

  // Per-state control vector; all fields default to 0 / ALUOp add.
  always_comb begin
    ctrl_s = '0;
    case (state_s)
      S_FETCH: begin
        ctrl_s.iord      = 1'b0;
        ctrl_s.alu_src_a = 1'b0;
        ctrl_s.alu_src_b = SRCB_FOUR;
        ctrl_s.alu_op    = ALUOP_ADD;
        ctrl_s.pc_src    = PCSRC_ALU;
        // IR and PC only load once the read has actually completed.
        ctrl_s.ir_write  = mem_ready_i;
        ctrl_s.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_s.alu_src_a  = 1'b0;
        ctrl_s.alu_src_b  = SRCB_IMM_SH;
        ctrl_s.alu_op     = ALUOP_ADD;
        ctrl_s.illegal_op = (decode_target(opcode_i) == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_ADD;
      end
      S_ORIEX: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_ORI;
      end
      S_MEMRD: begin
        ctrl_s.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl_s.reg_dst    = 1'b0;
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_s.iord      = 1'b1;
        ctrl_s.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_B;
        ctrl_s.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_s.reg_dst    = 1'b1;
        ctrl_s.mem_to_reg = 1'b0;
        ctrl_s.reg_write  = 1'b1;
      end
      S_IWB: begin
        ctrl_s.reg_dst    = 1'b0;
        ctrl_s.mem_to_reg = 1'b0;
        ctrl_s.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_B;
        ctrl_s.pc_src    = PCSRC_ALUOUT;
`ifdef BNE_EN
        if (opcode_i == OP_BNE) begin
          ctrl_s.alu_op    = ALUOP_SUB;
          ctrl_s.branch_ne = 1'b1;
        end else begin
          ctrl_s.alu_op = ALUOP_BEQ;
          ctrl_s.branch = 1'b1;
        end
`else
        ctrl_s.alu_op = ALUOP_BEQ;
        ctrl_s.branch = 1'b1;
`endif
      end
      S_JUMP: begin
        ctrl_s.pc_src   = PCSRC_JUMP;
        ctrl_s.pc_write = 1'b1;
      end
      default: begin
        ctrl_s = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle MIPS datapath. Holds the state register
// and next-state logic; the Moore output decode lives in ctrl_output_decode.
// Ports:
//   clk, reset (async, active-high -> FETCH)
//   opcode[5:0], mem_ready                       inputs
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB[1:0], ALUOp[2:0], PCSrc[1:0], PCWrite, Branch, BranchNe,
//   illegal_op                                   control outputs
// Optional feature macro: BNE_EN (bne decodes to BRANCH, drives BranchNe);
// without it bne is illegal and BranchNe stays 0.
// ---------------------------------------------------------------------------
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Branch,
  output logic       BranchNe,
  output logic       illegal_op
);

  state_t            state_q;
  state_t            state_d;
  logic [CTRL_W-1:0] ctrl_vec_s;
  ctrl_t             ctrl_s;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_ready only matters in FETCH, MEMRD and MEMWR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        state_d = decode_target(opcode);
      end
      S_MEMADR: begin
        // Only lw/sw reach MEMADR, so anything but sw is a load.
        if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_EXECUTE:          state_d = S_ALUWB;
      S_ADDIEX, S_ORIEX:  state_d = S_IWB;
      S_MEMWB, S_ALUWB,
      S_IWB, S_BRANCH,
      S_JUMP:             state_d = S_FETCH;
      default:            state_d = S_FETCH;
    endcase
  end

  ctrl_output_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_vec_s)
  );

  assign ctrl_s = ctrl_t'(ctrl_vec_s);

  // Mux selects pass straight through (state is already FETCH during reset).
  assign IorD     = ctrl_s.iord;
  assign RegDst   = ctrl_s.reg_dst;
  assign MemtoReg = ctrl_s.mem_to_reg;
  assign ALUSrcA  = ctrl_s.alu_src_a;
  assign ALUSrcB  = ctrl_s.alu_src_b;
  assign ALUOp    = ctrl_s.alu_op;
  assign PCSrc    = ctrl_s.pc_src;

  // Write enables are blocked while reset is held, even though FETCH with
  // mem_ready=1 would otherwise assert IRWrite/PCWrite.
  assign MemWrite   = ctrl_s.mem_write  & ~reset;
  assign IRWrite    = ctrl_s.ir_write   & ~reset;
  assign RegWrite   = ctrl_s.reg_write  & ~reset;
  assign PCWrite    = ctrl_s.pc_write   & ~reset;
  assign Branch     = ctrl_s.branch     & ~reset;
  assign BranchNe   = ctrl_s.branch_ne  & ~reset;
  assign illegal_op = ctrl_s.illegal_op & ~reset;

endmodule
